// File: rtl/fp_mult_result_stage.sv
// Result stage behind the combinational FP32 multiplier: IEEE special-case and
// exponent-range fix-ups, a 2-entry output FIFO and sticky exception flags.
module fp_mult_result_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_opcode,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic [4:0]  out_flags,
  output logic [4:0]  flags_sticky,
  input  logic        flags_clr
);

  localparam logic [1:0]  OP_MUL  = 2'b01;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [4:0]  F_NV    = 5'b10000;
  localparam logic [4:0]  F_OF_NX = 5'b00101;
  localparam logic [4:0]  F_UF_NX = 5'b00011;

  logic        w_sign;
  logic [7:0]  w_ex, w_ey, w_c;
  logic        w_nan_x, w_nan_y, w_snan_x, w_snan_y;
  logic        w_inf_x, w_inf_y, w_zero_x, w_zero_y;
  // One bit wider than needed so a malformed raw exponent cannot wrap the range test.
  logic signed [10:0] w_e_unb, w_e;
  logic [31:0] w_fix_r;
  logic [4:0]  w_fix_f;

  assign w_sign   = in_x[31] ^ in_y[31];
  assign w_ex     = in_x[30:23];
  assign w_ey     = in_y[30:23];
  assign w_nan_x  = (w_ex == 8'hFF) && (in_x[22:0] != 23'h0);
  assign w_nan_y  = (w_ey == 8'hFF) && (in_y[22:0] != 23'h0);
  assign w_snan_x = w_nan_x && !in_x[22];
  assign w_snan_y = w_nan_y && !in_y[22];
  assign w_inf_x  = (w_ex == 8'hFF) && (in_x[22:0] == 23'h0);
  assign w_inf_y  = (w_ey == 8'hFF) && (in_y[22:0] == 23'h0);
  assign w_zero_x = (w_ex == 8'h00);
  assign w_zero_y = (w_ey == 8'h00);

  assign w_e_unb = $signed({3'b000, w_ex}) + $signed({3'b000, w_ey}) - 11'sd127;
  assign w_c     = in_r[30:23] - w_e_unb[7:0];
  assign w_e     = w_e_unb + $signed({3'b000, w_c});

  always_comb begin
    w_fix_r = in_r;
    w_fix_f = 5'b00000;
    if (in_opcode == OP_MUL) begin
      if (w_nan_x || w_nan_y) begin
        w_fix_r = QNAN;
        w_fix_f = (w_snan_x || w_snan_y) ? F_NV : 5'b00000;
      end else if ((w_inf_x && w_zero_y) || (w_inf_y && w_zero_x)) begin
        w_fix_r = QNAN;
        w_fix_f = F_NV;
      end else if (w_inf_x || w_inf_y) begin
        w_fix_r = {w_sign, 8'hFF, 23'h0};
      end else if (w_zero_x || w_zero_y) begin
        w_fix_r = {w_sign, 31'h0};
      end else if (w_e >= 11'sd255) begin
        w_fix_r = {w_sign, 8'hFF, 23'h0};
        w_fix_f = F_OF_NX;
      end else if (w_e <= 11'sd0) begin
        w_fix_r = {w_sign, 31'h0};
        w_fix_f = F_UF_NX;
      end else begin
        w_fix_r = {w_sign, in_r[30:0]};
      end
    end
  end

  logic [31:0] r_mem_r [2];
  logic [4:0]  r_mem_f [2];
  logic        r_wr_ptr, r_rd_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_hold_r;
  logic [4:0]  r_hold_f;
  logic [4:0]  r_sticky;
  logic        w_push, w_pop;
  logic [31:0] w_head_r;
  logic [4:0]  w_head_f;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_head_r  = r_mem_r[r_rd_ptr];
  assign w_head_f  = r_mem_f[r_rd_ptr];

  // With the FIFO empty the last popped entry stays visible on the outputs.
  assign out_r        = out_valid ? w_head_r : r_hold_r;
  assign out_flags    = out_valid ? w_head_f : r_hold_f;
  assign flags_sticky = r_sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_r[0] <= 32'h0;
      r_mem_r[1] <= 32'h0;
      r_mem_f[0] <= 5'h0;
      r_mem_f[1] <= 5'h0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_hold_r   <= 32'h0;
      r_hold_f   <= 5'h0;
      r_sticky   <= 5'h0;
    end else begin
      if (w_push) begin
        r_mem_r[r_wr_ptr] <= w_fix_r;
        r_mem_f[r_wr_ptr] <= w_fix_f;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_hold_r <= w_head_r;
        r_hold_f <= w_head_f;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_pop)
        r_sticky <= (flags_clr ? 5'h0 : r_sticky) | w_head_f;
      else if (flags_clr)
        r_sticky <= 5'h0;
    end
  end

endmodule

// File: tb/tb_fp_mult_result_stage.sv
// Scoreboard bench for fp_mult_result_stage: a reference fix-up model feeds an
// expected-result queue that is checked against the FIFO head every cycle.
module tb_fp_mult_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_opcode;
  logic [31:0] in_x, in_y, in_r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic [4:0]  out_flags;
  logic [4:0]  flags_sticky;
  logic        flags_clr;

  int total = 0;
  int bad   = 0;

  logic [36:0] q[$];
  logic [4:0]  m_sticky;
  logic [31:0] m_last_r;
  logic [4:0]  m_last_f;
  logic        acc;

  always #5 clk = ~clk;

  fp_mult_result_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_x(in_x), .in_y(in_y), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_flags(out_flags),
    .flags_sticky(flags_sticky), .flags_clr(flags_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference fix-up, returns {flags, result}.
  function automatic logic [36:0] ref_model(input logic [1:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] r);
    int ex, ey, eu, c, e;
    logic s, nx, ny, snx, sny, ix, iy;
    if (op != 2'b01) return {5'b00000, r};
    s   = x[31] ^ y[31];
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    nx  = (ex == 255) && (x[22:0] != 0);
    ny  = (ey == 255) && (y[22:0] != 0);
    snx = nx && (x[22] == 1'b0);
    sny = ny && (y[22] == 1'b0);
    ix  = (ex == 255) && !nx;
    iy  = (ey == 255) && !ny;
    if (nx || ny) return {(snx || sny) ? 5'b10000 : 5'b00000, 32'h7FC00000};
    if ((ix && ey == 0) || (iy && ex == 0)) return {5'b10000, 32'h7FC00000};
    if (ix || iy) return {5'b00000, s, 31'h7F800000};
    if (ex == 0 || ey == 0) return {5'b00000, s, 31'h0};
    eu = ex + ey - 127;
    c  = (int'(r[30:23]) - eu) & 255;
    e  = eu + c;
    if (e >= 255) return {5'b00101, s, 31'h7F800000};
    if (e <= 0)   return {5'b00011, s, 31'h0};
    return {5'b00000, s, r[30:0]};
  endfunction

  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] r,
                      input logic ordy, input logic clr, output logic accepted);
    logic [36:0] head;
    logic do_pop, do_push;
    @(negedge clk);
    in_valid = v; in_opcode = op; in_x = x; in_y = y; in_r = r;
    out_ready = ordy; flags_clr = clr;
    #1;
    check_val("in_ready", {31'h0, in_ready}, {31'h0, q.size() != 2});
    check_val("out_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
    if (q.size() != 0) begin
      check_val("out_r", out_r, q[0][31:0]);
      check_val("out_flags", {27'h0, out_flags}, {27'h0, q[0][36:32]});
    end else begin
      check_val("out_r_hold", out_r, m_last_r);
      check_val("out_flags_hold", {27'h0, out_flags}, {27'h0, m_last_f});
    end
    check_val("flags_sticky", {27'h0, flags_sticky}, {27'h0, m_sticky});
    do_pop  = (q.size() != 0) && ordy;
    do_push = v && (q.size() != 2);
    accepted = do_push;
    if (do_pop) begin
      head     = q.pop_front();
      m_last_r = head[31:0];
      m_last_f = head[36:32];
      m_sticky = (clr ? 5'h0 : m_sticky) | head[36:32];
    end else if (clr) begin
      m_sticky = 5'h0;
    end
    if (do_push) q.push_back(ref_model(op, x, y, r));
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_opcode = 2'b01;
    in_x = 32'h40000000; in_y = 32'h40400000; in_r = 32'h40C00000;
    out_ready = 1'b0; flags_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_sticky = 5'h0; m_last_r = 32'h0; m_last_f = 5'h0;
    #1;
    check_val("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check_val("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check_val("rst_sticky", {27'h0, flags_sticky}, 32'h0);
    check_val("rst_out_r", out_r, 32'h0);
    check_val("rst_out_flags", {27'h0, out_flags}, 32'h0);
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic a;
    step(1'b0, 2'b01, 32'h0, 32'h0, 32'h0, ordy, clr, a);
  endtask

  task automatic mul(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                     input logic ordy);
    logic a;
    step(1'b1, 2'b01, x, y, r, ordy, 1'b0, a);
  endtask

  logic [31:0] specials [9];

  initial begin
    int n;
    specials[0] = 32'h00000000; specials[1] = 32'h80000000; specials[2] = 32'h00000001;
    specials[3] = 32'h7F800000; specials[4] = 32'hFF800000; specials[5] = 32'h7FC00000;
    specials[6] = 32'h7F800001; specials[7] = 32'hFFA00000; specials[8] = 32'h3F800000;
    rst = 1'b0; in_valid = 1'b0; in_opcode = 2'b00;
    in_x = 32'h0; in_y = 32'h0; in_r = 32'h0; out_ready = 1'b0; flags_clr = 1'b0;
    m_sticky = 5'h0; m_last_r = 32'h0; m_last_f = 5'h0;
    do_reset();

    mul(32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
    idle(1'b1, 1'b0);
    check_val("normal_result", m_last_r, 32'h40C00000);
    mul(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    check_val("of_sticky", {27'h0, flags_sticky}, 32'h00000005);
    mul(32'h00800000, 32'h3F000000, 32'h00000000, 1'b1);
    mul(32'h7F800000, 32'h80000000, 32'h12345678, 1'b1);
    mul(32'h7F800001, 32'h3F800000, 32'h12345678, 1'b1);
    mul(32'hFF800000, 32'h40000000, 32'h12345678, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);

    // Backpressure: third op held until a pop frees a slot.
    mul(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    mul(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0);
    step(1'b1, 2'b00, 32'h1, 32'h2, 32'h12345678, 1'b0, 1'b0, acc);
    check_val("third_held", {31'h0, acc}, 32'h0);
    n = 0;
    while (!acc && n < 10) begin
      step(1'b1, 2'b00, 32'h1, 32'h2, 32'h12345678, 1'b1, 1'b0, acc);
      n++;
    end
    check_val("third_accepted", {31'h0, acc}, 32'h1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check_val("passthru", m_last_r, 32'h12345678);

    // Push and pop in the same cycle at one entry.
    mul(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    mul(32'h00800000, 32'h3F000000, 32'h00000000, 1'b1);
    mul(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Reset with two entries queued.
    mul(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    mul(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0);
    idle(1'b0, 1'b0);
    do_reset();
    idle(1'b1, 1'b0);

    // Clear coincident with popping an OF entry, then clear alone.
    mul(32'h7F800000, 32'h80000000, 32'h0, 1'b0);
    idle(1'b1, 1'b0);
    mul(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check_val("clr_pop_sticky", {27'h0, flags_sticky}, 32'h00000005);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] x, y, r;
      logic [1:0]  op;
      int eu;
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      if ($urandom_range(0, 4) == 0) begin
        x = specials[$urandom_range(0, 8)];
        y = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 8)] : $urandom;
        r = $urandom;
      end else begin
        x  = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        y  = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        eu = int'(x[30:23]) + int'(y[30:23]) - 127 + int'($urandom_range(0, 2));
        r  = {1'($urandom), 8'(eu), 23'($urandom)};
      end
      step(1'($urandom_range(0, 1)), op, x, y, r, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 15) == 0), acc);
    end

    n = 0;
    while (q.size() != 0 && n < 20) begin
      idle(1'b1, 1'b0);
      n++;
    end
    check_val("drain_empty", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mult_result_stage.md
# fp_mult_result_stage

Registered post-processing stage downstream of the combinational FP32 multiplier datapath. It captures the raw multiplier result together with the operands that produced it, then applies IEEE special-case and exponent-range fix-ups that the datapath does not handle (NaN, infinity, zero/subnormal, overflow, underflow). Results are buffered in a 2-entry FIFO behind a valid/ready handshake, and sticky exception flags are accumulated. Non-multiply opcodes pass through unmodified.

## Interface
- No parameters; FIFO depth fixed at 2.
- clk  in  1  clock; single clock domain, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready
- in_opcode  in  2  00 Add, 01 Mul, 10 Sqrt, 11 Div
- in_x  in  32  operand X as applied to the multiplier
- in_y  in  32  operand Y as applied to the multiplier
- in_r  in  32  raw multiplier result for in_x, in_y
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts; pop when out_valid & out_ready
- out_r  out  32  fixed-up result at FIFO head
- out_flags  out  5  {NV, DZ, OF, UF, NX} for head entry
- flags_sticky  out  5  OR of out_flags over all popped entries since reset/clear
- flags_clr  in  1  clear sticky flags

## Operation
- Fix-up is combinational on accepted inputs; the result is written into the FIFO on the accepting edge.
- Opcode != 01: out_r = in_r, flags = 0.
- Opcode 01, evaluated in priority order:
  - sign s = x[31]^y[31]; ex = x[30:23], ey = y[30:23]; NaN = exp FF with frac != 0; sNaN = NaN with frac[22] = 0.
  - Either operand NaN: result 0x7FC00000; NV set if either operand is sNaN.
  - Inf × (exp 00): result 0x7FC00000, NV.
  - Either operand inf: result {s, 0xFF, 23'h0}, flags 0.
  - Either operand exp 00 (zero or subnormal, flushed): result {s, 31'h0}, flags 0.
  - Otherwise:
    - e_unb = ex + ey − 127, 10-bit signed.
    - c = (in_r[30:23] − e_unb[7:0]) mod 256, range 0..2 (normalization plus rounding carry).
    - e = e_unb + c.
    - e ≥ 255: result {s, 0xFF, 0}, OF|NX.
    - e ≤ 0: result {s, 31'h0}, UF|NX.
    - Else: result {s, in_r[30:0]}, flags 0.
  - NX is reported only for overflow and underflow. DZ is never set by this block and is reserved for divide.
- FIFO:
  - 2 entries; each holds 32-bit result and 5 flags.
  - Strict in-order delivery.
  - count ∈ {0,1,2}.
  - in_ready = (count != 2), derived from registered count only; it has no combinational path from out_ready.
  - Push and pop in the same cycle with count = 1: count stays 1, head advances correctly.
  - With count = 2, no push is possible even when popping that cycle.
- Sticky flags:
  - On pop: flags_sticky ← flags_sticky | out_flags.
  - flags_clr in the same cycle as a pop: flags_sticky ← popped out_flags (clear first, then OR).
  - flags_clr alone: flags_sticky ← 0.
- Reset:
  - count = 0, out_valid = 0, out_r = 0, out_flags = 0, flags_sticky = 0, in_ready = 1 in the cycle after rst.
  - In-flight entries are discarded.
  - An in_valid asserted during rst is not accepted.

## Timing
- Latency: an accept at edge N produces out_valid = 1 from N+1 when the FIFO was empty.
- Throughput: 1 per cycle while out_ready = 1.
- Sustained out_ready = 0: accepts exactly 2, then in_ready = 0 until a pop. in_ready rises on the edge after the first pop.
- out_r and out_flags stay stable while out_valid & !out_ready.
- When count = 0, out_r holds its last value, or 0 after reset.

## Test plan
- Normal multiply: opcode 01, X=0x40000000, Y=0x40400000, R=0x40C00000 -> out_r=0x40C00000, flags 0, out_valid one cycle after accept.
- Overflow: X=0x7F000000, Y=0x40000000, R=0x7F800000 -> out_r=0x7F800000, flags OF|NX (5'b00101); flags_sticky=5'b00101 after pop.
- Underflow: X=0x00800000, Y=0x3F000000, R=0x00000000 -> out_r=0x00000000, flags UF|NX.
- Specials:
  - X=0x7F800000, Y=0x80000000 -> 0x7FC00000, NV.
  - X=0x7F800001 (sNaN), Y=0x3F800000 -> 0x7FC00000, NV.
  - X=0xFF800000, Y=0x40000000 -> 0xFF800000, flags 0.
- Backpressure/order:
  - out_ready=0, push three ops back-to-back -> third held (in_ready=0 after second).
  - Raise out_ready -> outputs in push order; push/pop same cycle at count=1 keeps count=1.
  - Opcode 00 with R=0x12345678 passes through unchanged.
- Reset/clear:
  - rst asserted with 2 entries queued -> next cycle out_valid=0, in_ready=1, flags_sticky=0.
  - flags_clr coincident with popping an OF entry -> flags_sticky=5'b00101.
